// File: rtl/regfile_pkg.sv
// Shared defaults and types for the MiniMicro multi-port register file.
// The PC sits at the all-ones address, so there is one register fewer than addresses.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_REGS = (1 << DEF_ADDR_W) - 1;
  localparam logic [DEF_ADDR_W-1:0] PC_ADDR = DEF_ADDR_W'(NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Tracks registers that are waiting on a load.
// Flags a read port whose register still has a load in flight.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  input  logic                       clr,
  input  logic [ADDR_W-1:0]          clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic [NUM_RD-1:0]          rd_hazard
);
  localparam logic [ADDR_W-1:0] PC_A = '1;

  // The set is applied last, so it wins when a new load reuses the register being retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr)    busy[clr_addr] <= 1'b0;
      if (sb_set) busy[sb_addr]  <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_hz
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[g*ADDR_W +: ADDR_W];
    // A forwarded load resolves the hazard in the same cycle; PC reads are never forwarded.
    assign rd_hazard[g] = busy[ra] && !(BYPASS && clr && (clr_addr == ra) && (ra != PC_A));
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD read ports, ALU and load write ports,
// pending-load scoreboard, and PC writes redirected to fetch.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int PC_OFFSET = 8,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_hazard,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic                       pc_wr_valid,
  output logic [DATA_W-1:0]          pc_wr_data
);
  localparam int REGS = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] PC_A = '1;

  logic                ld_accept;
  logic                w_en;
  logic                w_pc;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W-1:0]   regs [REGS];

  // ALU writeback has priority; the load port stalls whenever it is active.
  assign ld_ready  = !wa_en;
  assign ld_accept = ld_valid && ld_ready;
  assign w_en      = wa_en || ld_accept;
  assign w_addr    = wa_en ? wa_addr : ld_addr;
  assign w_data    = wa_en ? wa_data : ld_data;
  assign w_pc      = w_en && (w_addr == PC_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (w_en && !w_pc) begin
      regs[w_addr] <= w_data;
    end
  end

  // PC-address writes never reach storage; fetch sees them as a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_wr_valid <= 1'b0;
      pc_wr_data  <= '0;
    end else begin
      pc_wr_valid <= w_pc;
      if (w_pc) pc_wr_data <= w_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    assign ra = rd_addr[g*ADDR_W +: ADDR_W];
    always_comb begin
      if (ra == PC_A)
        rv = pc_in + DATA_W'(PC_OFFSET);
      else if (BYPASS && w_en && (w_addr == ra))
        rv = w_data;
      else
        rv = regs[ra];
    end
    assign rd_data[g*DATA_W +: DATA_W] = rv;
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .clr       (ld_accept),
    .clr_addr  (ld_addr),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .rd_hazard (rd_hazard)
  );
endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: a bypassing and a non-bypassing register file share stimulus;
// expectations are queued by the stimulus thread and compared by a negedge monitor.
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int K_RD = 0, K_RD_NB = 1, K_HZ = 2, K_HZ_NB = 3,
                 K_BUSY = 4, K_PCV = 5, K_PCD = 6, K_LDR = 7;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  reg_data_t   pc_in, wa_data, ld_data;
  logic        wa_en, ld_valid, sb_set;
  reg_addr_t   wa_addr, ld_addr, sb_addr;

  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_hazard, rd_hazard_nb;
  logic [15:0] busy, busy_nb;
  logic        ld_ready, ld_ready_nb, pc_wr_valid, pc_wr_valid_nb;
  reg_data_t   pc_wr_data, pc_wr_data_nb;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hazard(rd_hazard),
    .pc_in(pc_in), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy),
    .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data)
  );

  register_file_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_hazard(rd_hazard_nb),
    .pc_in(pc_in), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready_nb), .ld_addr(ld_addr), .ld_data(ld_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy_nb),
    .pc_wr_valid(pc_wr_valid_nb), .pc_wr_data(pc_wr_data_nb)
  );

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_RD:    return rd_data[idx*32 +: 32];
      K_RD_NB: return rd_data_nb[idx*32 +: 32];
      K_HZ:    return {31'b0, rd_hazard[idx]};
      K_HZ_NB: return {31'b0, rd_hazard_nb[idx]};
      K_BUSY:  return {16'b0, busy};
      K_PCV:   return {31'b0, pc_wr_valid};
      K_PCD:   return pc_wr_data;
      K_LDR:   return {31'b0, ld_ready};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = exp_q.pop_front();
        a = actual(e.kind, e.idx);
        checks++;
        if (a !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, a, e.val);
        end
      end
    end
  end

  task automatic check_output(input int kind, input int idx, input logic [31:0] val,
                              input string name);
    exp_q.push_back('{kind, idx, val, name});
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    wa_en    = 1'b0;
    ld_valid = 1'b0;
    sb_set   = 1'b0;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; pc_in = 32'h100;
    wa_en = 0; wa_addr = '0; wa_data = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0;
    sb_set = 0; sb_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and every address
    check_output(K_BUSY, 0, 32'h0, "reset_busy");
    check_output(K_PCV, 0, 32'h0, "reset_pcv");
    check_output(K_PCD, 0, 32'h0, "reset_pcd");
    check_output(K_LDR, 0, 32'h1, "reset_ldr");
    for (int a = 0; a < 8; a++) begin
      set_rd(4'(2*a), 4'(2*a+1));
      check_output(K_RD, 0, 32'h0, $sformatf("reset_r%0d", 2*a));
      check_output(K_RD, 1, (2*a+1 == 15) ? 32'h108 : 32'h0, $sformatf("reset_r%0d", 2*a+1));
      apply_stimulus();
    end

    // ALU write with same-cycle read
    wa_en = 1; wa_addr = 3; wa_data = 32'hDEADBEEF; set_rd(3, 0);
    check_output(K_RD, 0, 32'hDEADBEEF, "bypass_r3");
    check_output(K_RD_NB, 0, 32'h0, "nobypass_r3");
    check_output(K_LDR, 0, 32'h0, "ldr_during_alu");
    apply_stimulus();
    set_rd(3, 0);
    check_output(K_RD, 0, 32'hDEADBEEF, "stored_r3");
    check_output(K_RD_NB, 0, 32'hDEADBEEF, "stored_r3_nb");
    apply_stimulus();

    // Load stalled behind ALU write, then accepted
    wa_en = 1; wa_addr = 6; wa_data = 32'h66;
    ld_valid = 1; ld_addr = 5; ld_data = 32'h55; set_rd(5, 6);
    check_output(K_LDR, 0, 32'h0, "ld_stalled");
    check_output(K_RD, 0, 32'h0, "r5_not_yet");
    check_output(K_RD, 1, 32'h66, "r6_bypass");
    apply_stimulus();
    ld_valid = 1; ld_addr = 5; ld_data = 32'h55; set_rd(5, 6);
    check_output(K_LDR, 0, 32'h1, "ld_ready");
    check_output(K_RD, 0, 32'h55, "r5_ld_bypass");
    check_output(K_RD_NB, 0, 32'h0, "r5_nb_before_edge");
    check_output(K_RD, 1, 32'h66, "r6_stored");
    apply_stimulus();
    set_rd(5, 6);
    check_output(K_RD_NB, 0, 32'h55, "r5_stored");
    check_output(K_RD_NB, 1, 32'h66, "r6_stored_nb");
    apply_stimulus();

    // Scoreboard set, hazard, clear via load, set-wins
    sb_set = 1; sb_addr = 7; set_rd(7, 0);
    check_output(K_HZ, 0, 32'h0, "hz_before_edge");
    apply_stimulus();
    set_rd(7, 0);
    check_output(K_HZ, 0, 32'h1, "hz_r7");
    check_output(K_BUSY, 0, 32'h80, "busy_r7");
    apply_stimulus();
    ld_valid = 1; ld_addr = 7; ld_data = 32'h77; set_rd(7, 0);
    check_output(K_RD, 0, 32'h77, "r7_ld_bypass");
    check_output(K_HZ, 0, 32'h0, "hz_bypassed");
    check_output(K_HZ_NB, 0, 32'h1, "hz_nb_not_bypassed");
    apply_stimulus();
    set_rd(7, 0);
    check_output(K_BUSY, 0, 32'h0, "busy_cleared");
    check_output(K_RD_NB, 0, 32'h77, "r7_stored");
    apply_stimulus();
    sb_set = 1; sb_addr = 7; ld_valid = 1; ld_addr = 7; ld_data = 32'h78;
    apply_stimulus();
    set_rd(7, 0);
    check_output(K_BUSY, 0, 32'h80, "set_wins");
    check_output(K_HZ, 0, 32'h1, "hz_after_set_wins");
    check_output(K_RD_NB, 0, 32'h78, "r7_second_load");
    apply_stimulus();
    ld_valid = 1; ld_addr = 7; ld_data = 32'h79;
    apply_stimulus();
    check_output(K_BUSY, 0, 32'h0, "busy_cleared_again");
    apply_stimulus();

    // PC redirect and PC-read wraparound
    wa_en = 1; wa_addr = 15; wa_data = 32'h2000;
    check_output(K_PCV, 0, 32'h0, "pcv_before_edge");
    apply_stimulus();
    wa_en = 1; wa_addr = 15; wa_data = 32'h3000;
    check_output(K_PCV, 0, 32'h1, "pcv_first");
    check_output(K_PCD, 0, 32'h2000, "pcd_first");
    apply_stimulus();
    set_rd(3, 0);
    check_output(K_PCV, 0, 32'h1, "pcv_back_to_back");
    check_output(K_PCD, 0, 32'h3000, "pcd_back_to_back");
    check_output(K_RD_NB, 0, 32'hDEADBEEF, "r3_untouched_by_pc");
    apply_stimulus();
    check_output(K_PCV, 0, 32'h0, "pcv_one_cycle");
    apply_stimulus();
    pc_in = 32'hFFFFFFFC; wa_en = 1; wa_addr = 15; wa_data = 32'h5000; set_rd(15, 15);
    check_output(K_RD, 0, 32'h4, "pc_read_wrap");
    check_output(K_RD_NB, 1, 32'h4, "pc_read_wrap_nb");
    apply_stimulus();
    pc_in = 32'h100;
    check_output(K_PCV, 0, 32'h1, "pcv_third");
    check_output(K_PCD, 0, 32'h5000, "pcd_third");
    apply_stimulus();

    // Asynchronous reset in mid-handshake
    sb_set = 1; sb_addr = 9; wa_en = 1; wa_addr = 15; wa_data = 32'h6000;
    apply_stimulus();
    wa_en = 1; wa_addr = 2; wa_data = 32'h22;
    ld_valid = 1; ld_addr = 10; ld_data = 32'hAA;
    #2 rst = 1'b1;
    #1;
    check_output(K_BUSY, 0, 32'h0, "async_busy");
    check_output(K_PCV, 0, 32'h0, "async_pcv");
    check_output(K_PCD, 0, 32'h0, "async_pcd");
    check_output(K_LDR, 0, 32'h0, "ldr_in_reset_alu");
    apply_stimulus();
    ld_valid = 1; ld_addr = 10; ld_data = 32'hAA;
    check_output(K_LDR, 0, 32'h1, "ldr_in_reset");
    apply_stimulus();
    rst = 1'b0; set_rd(10, 2);
    check_output(K_RD_NB, 0, 32'h0, "r10_dropped");
    check_output(K_RD_NB, 1, 32'h0, "r2_dropped");
    apply_stimulus();
    set_rd(3, 0);
    check_output(K_RD_NB, 0, 32'h0, "r3_cleared");
    apply_stimulus();
    ld_valid = 1; ld_addr = 10; ld_data = 32'hAA;
    apply_stimulus();
    set_rd(10, 0);
    check_output(K_RD_NB, 0, 32'hAA, "r10_represented");
    apply_stimulus();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
